// File: rtl/rob_pkg.sv
// Sizes and entry layout shared by the two-wide reorder buffer.
// ROB_ENABLE_BRANCH_RECOVERY_EN adds branch/mispredict bits to every entry.
package rob_pkg;

  localparam int ROB_SIZE = 32;
  localparam int ROB_IDX  = $clog2(ROB_SIZE);
  localparam int ARF_IDX  = 5;
  localparam int PRF_IDX  = 6;

  typedef struct packed {
    logic               valid;
    logic               complete;
`ifdef ROB_ENABLE_BRANCH_RECOVERY_EN
    logic               is_branch;
    logic               mispredict;
`endif
    logic [ARF_IDX-1:0] dest;
    logic [PRF_IDX-1:0] prf;
    logic [PRF_IDX-1:0] old_prf;
  } rob_entry_t;

endpackage

// File: rtl/rob.sv
// Two-wide in-order-retire reorder buffer: two dispatch slots, two CDB completions, two commits.
// Optional feature: define ROB_ENABLE_BRANCH_RECOVERY_EN for mispredict flush on commit.
module rob
  import rob_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               dispatch_en_1,
  input  logic               dispatch_en_2,
  input  logic [ARF_IDX-1:0] dispatch_dest_reg_1,
  input  logic [ARF_IDX-1:0] dispatch_dest_reg_2,
  input  logic [PRF_IDX-1:0] dispatch_PRF_reg_1,
  input  logic [PRF_IDX-1:0] dispatch_PRF_reg_2,
  input  logic [PRF_IDX-1:0] dispatch_old_PRF_reg_1,
  input  logic [PRF_IDX-1:0] dispatch_old_PRF_reg_2,
  input  logic               complete_en_1,
  input  logic               complete_en_2,
  input  logic [ROB_IDX-1:0] complete_rob_idx_1,
  input  logic [ROB_IDX-1:0] complete_rob_idx_2,
  output logic [ROB_IDX-1:0] rob_idx_1,
  output logic [ROB_IDX-1:0] rob_idx_2,
  output logic               rob_stall,
  output logic               ROB_empty,
  output logic               commit_en_1,
  output logic               commit_en_2,
  output logic [ARF_IDX-1:0] ROB_dest_reg_1,
  output logic [ARF_IDX-1:0] ROB_dest_reg_2,
  output logic [PRF_IDX-1:0] ROB_PRF_reg_1,
  output logic [PRF_IDX-1:0] ROB_PRF_reg_2,
  output logic [PRF_IDX-1:0] ROB_old_PRF_reg_1,
`ifdef ROB_ENABLE_BRANCH_RECOVERY_EN
  input  logic               dispatch_is_branch_1,
  input  logic               dispatch_is_branch_2,
  input  logic               complete_mispredict_1,
  input  logic               complete_mispredict_2,
  output logic               branch_recover,
`endif
  output logic [PRF_IDX-1:0] ROB_old_PRF_reg_2
);

  localparam logic [ROB_IDX:0] STALL_LEVEL = (ROB_IDX+1)'(ROB_SIZE - 2);

  rob_entry_t         entries [ROB_SIZE];
  rob_entry_t         head_entry;
  rob_entry_t         next_entry;
  logic [ROB_IDX-1:0] head;
  logic [ROB_IDX-1:0] tail;
  logic [ROB_IDX-1:0] head_plus1;
  logic [ROB_IDX-1:0] tail_plus1;
  logic [ROB_IDX:0]   count;
  logic [ROB_IDX:0]   num_dispatch;
  logic [ROB_IDX:0]   num_commit;
  logic               accept_1;
  logic               accept_2;
  logic               flush;

  assign head_plus1 = head + 1'b1;
  assign tail_plus1 = tail + 1'b1;
  assign rob_idx_1  = tail;
  assign rob_idx_2  = tail_plus1;

  // Stall looks only at the registered count so this cycle's commits never unblock dispatch.
  assign rob_stall  = count > STALL_LEVEL;
  assign ROB_empty  = count == '0;

  assign accept_1     = dispatch_en_1 & ~rob_stall;
  assign accept_2     = accept_1 & dispatch_en_2;
  assign num_dispatch = {{ROB_IDX{1'b0}}, accept_1} + {{ROB_IDX{1'b0}}, accept_2};
  assign num_commit   = {{ROB_IDX{1'b0}}, commit_en_1} + {{ROB_IDX{1'b0}}, commit_en_2};

  always_comb begin
    head_entry  = entries[head];
    next_entry  = entries[head_plus1];
    commit_en_1 = head_entry.valid & head_entry.complete;
    commit_en_2 = commit_en_1 & next_entry.valid & next_entry.complete;
    flush       = 1'b0;
`ifdef ROB_ENABLE_BRANCH_RECOVERY_EN
    // A mispredicted branch still retires, but nothing younger than it may.
    if (commit_en_1 && head_entry.is_branch && head_entry.mispredict) begin
      commit_en_2 = 1'b0;
      flush       = 1'b1;
    end else if (commit_en_2 && next_entry.is_branch && next_entry.mispredict) begin
      flush       = 1'b1;
    end
`endif
    ROB_dest_reg_1    = head_entry.dest;
    ROB_dest_reg_2    = next_entry.dest;
    ROB_PRF_reg_1     = head_entry.prf;
    ROB_PRF_reg_2     = next_entry.prf;
    ROB_old_PRF_reg_1 = head_entry.old_prf;
    ROB_old_PRF_reg_2 = next_entry.old_prf;
  end

`ifdef ROB_ENABLE_BRANCH_RECOVERY_EN
  assign branch_recover = flush;
`endif

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < ROB_SIZE; i++) entries[i] <= '0;
    end else begin
      if (complete_en_1 && entries[complete_rob_idx_1].valid) begin
        entries[complete_rob_idx_1].complete <= 1'b1;
`ifdef ROB_ENABLE_BRANCH_RECOVERY_EN
        if (complete_mispredict_1) entries[complete_rob_idx_1].mispredict <= 1'b1;
`endif
      end
      if (complete_en_2 && entries[complete_rob_idx_2].valid) begin
        entries[complete_rob_idx_2].complete <= 1'b1;
`ifdef ROB_ENABLE_BRANCH_RECOVERY_EN
        if (complete_mispredict_2) entries[complete_rob_idx_2].mispredict <= 1'b1;
`endif
      end
      if (commit_en_1) entries[head].valid <= 1'b0;
      if (commit_en_2) entries[head_plus1].valid <= 1'b0;
      // Free slots at tail are never valid, so these writes cannot collide with commits.
      if (accept_1) begin
        entries[tail].valid    <= 1'b1;
        entries[tail].complete <= 1'b0;
        entries[tail].dest     <= dispatch_dest_reg_1;
        entries[tail].prf      <= dispatch_PRF_reg_1;
        entries[tail].old_prf  <= dispatch_old_PRF_reg_1;
`ifdef ROB_ENABLE_BRANCH_RECOVERY_EN
        entries[tail].is_branch  <= dispatch_is_branch_1;
        entries[tail].mispredict <= 1'b0;
`endif
      end
      if (accept_2) begin
        entries[tail_plus1].valid    <= 1'b1;
        entries[tail_plus1].complete <= 1'b0;
        entries[tail_plus1].dest     <= dispatch_dest_reg_2;
        entries[tail_plus1].prf      <= dispatch_PRF_reg_2;
        entries[tail_plus1].old_prf  <= dispatch_old_PRF_reg_2;
`ifdef ROB_ENABLE_BRANCH_RECOVERY_EN
        entries[tail_plus1].is_branch  <= dispatch_is_branch_2;
        entries[tail_plus1].mispredict <= 1'b0;
`endif
      end
      head  <= head + num_commit[ROB_IDX-1:0];
      tail  <= tail + num_dispatch[ROB_IDX-1:0];
      count <= count + num_dispatch - num_commit;
    end
  end

endmodule

// File: tb/tb_rob.sv
// Self-checking bench for rob: directed scenarios plus random traffic against a program-order queue model.
// Define ROB_ENABLE_BRANCH_RECOVERY_EN to also exercise mispredict recovery.
module tb_rob;
  import rob_pkg::*;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               dispatch_en_1, dispatch_en_2;
  logic [ARF_IDX-1:0] dispatch_dest_reg_1, dispatch_dest_reg_2;
  logic [PRF_IDX-1:0] dispatch_PRF_reg_1, dispatch_PRF_reg_2;
  logic [PRF_IDX-1:0] dispatch_old_PRF_reg_1, dispatch_old_PRF_reg_2;
  logic               complete_en_1, complete_en_2;
  logic [ROB_IDX-1:0] complete_rob_idx_1, complete_rob_idx_2;
  logic [ROB_IDX-1:0] rob_idx_1, rob_idx_2;
  logic               rob_stall, ROB_empty, commit_en_1, commit_en_2;
  logic [ARF_IDX-1:0] ROB_dest_reg_1, ROB_dest_reg_2;
  logic [PRF_IDX-1:0] ROB_PRF_reg_1, ROB_PRF_reg_2;
  logic [PRF_IDX-1:0] ROB_old_PRF_reg_1, ROB_old_PRF_reg_2;
`ifdef ROB_ENABLE_BRANCH_RECOVERY_EN
  logic               dispatch_is_branch_1, dispatch_is_branch_2;
  logic               complete_mispredict_1, complete_mispredict_2;
  logic               branch_recover;
`endif

  always #5 clock = ~clock;

  rob dut (
    .clock                  (clock),
    .reset                  (reset),
    .dispatch_en_1          (dispatch_en_1),
    .dispatch_en_2          (dispatch_en_2),
    .dispatch_dest_reg_1    (dispatch_dest_reg_1),
    .dispatch_dest_reg_2    (dispatch_dest_reg_2),
    .dispatch_PRF_reg_1     (dispatch_PRF_reg_1),
    .dispatch_PRF_reg_2     (dispatch_PRF_reg_2),
    .dispatch_old_PRF_reg_1 (dispatch_old_PRF_reg_1),
    .dispatch_old_PRF_reg_2 (dispatch_old_PRF_reg_2),
    .complete_en_1          (complete_en_1),
    .complete_en_2          (complete_en_2),
    .complete_rob_idx_1     (complete_rob_idx_1),
    .complete_rob_idx_2     (complete_rob_idx_2),
    .rob_idx_1              (rob_idx_1),
    .rob_idx_2              (rob_idx_2),
    .rob_stall              (rob_stall),
    .ROB_empty              (ROB_empty),
    .commit_en_1            (commit_en_1),
    .commit_en_2            (commit_en_2),
    .ROB_dest_reg_1         (ROB_dest_reg_1),
    .ROB_dest_reg_2         (ROB_dest_reg_2),
    .ROB_PRF_reg_1          (ROB_PRF_reg_1),
    .ROB_PRF_reg_2          (ROB_PRF_reg_2),
    .ROB_old_PRF_reg_1      (ROB_old_PRF_reg_1),
`ifdef ROB_ENABLE_BRANCH_RECOVERY_EN
    .dispatch_is_branch_1   (dispatch_is_branch_1),
    .dispatch_is_branch_2   (dispatch_is_branch_2),
    .complete_mispredict_1  (complete_mispredict_1),
    .complete_mispredict_2  (complete_mispredict_2),
    .branch_recover         (branch_recover),
`endif
    .ROB_old_PRF_reg_2      (ROB_old_PRF_reg_2)
  );

  // Model: live instructions oldest-first, each tagged with the ROB index it was given.
  typedef struct {
    int idx;
    int dest;
    int prf;
    int old_prf;
    bit complete;
    bit is_branch;
    bit mispredict;
  } model_entry_t;

  model_entry_t model_q[$];
  int           model_tail = 0;
  bit           exp_commit_1, exp_commit_2, exp_recover;
  int           checks = 0;
  int           failures = 0;

  bit st_reset, st_d1, st_d2, st_c1, st_c2, st_br1, st_br2, st_mp1, st_mp2;
  int st_dest1, st_dest2, st_prf1, st_prf2, st_old1, st_old2, st_ci1, st_ci2;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0d expected=%0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic clearStimulus();
    st_reset = 0; st_d1 = 0; st_d2 = 0; st_c1 = 0; st_c2 = 0;
    st_br1 = 0; st_br2 = 0; st_mp1 = 0; st_mp2 = 0;
    st_ci1 = 0; st_ci2 = 0;
    st_dest1 = $urandom_range(0, 31); st_dest2 = $urandom_range(0, 31);
    st_prf1  = $urandom_range(0, 63); st_prf2  = $urandom_range(0, 63);
    st_old1  = $urandom_range(0, 63); st_old2  = $urandom_range(0, 63);
  endtask

  task automatic completeOldest();
    int found = 0;
    foreach (model_q[k]) begin
      if (!model_q[k].complete && found == 0) begin
        st_c1 = 1; st_ci1 = model_q[k].idx; found = 1;
      end else if (!model_q[k].complete && found == 1) begin
        st_c2 = 1; st_ci2 = model_q[k].idx; found = 2;
      end
    end
  endtask

  task automatic computeExpected();
    exp_commit_1 = model_q.size() > 0 && model_q[0].complete;
    exp_commit_2 = exp_commit_1 && model_q.size() > 1 && model_q[1].complete;
    exp_recover  = 0;
    if (exp_commit_1 && model_q[0].is_branch && model_q[0].mispredict) begin
      exp_commit_2 = 0;
      exp_recover  = 1;
    end else if (exp_commit_2 && model_q[1].is_branch && model_q[1].mispredict) begin
      exp_recover  = 1;
    end
  endtask

  task automatic markComplete(input bit en, input int idx, input bit mp);
    foreach (model_q[k]) begin
      if (en && model_q[k].idx == idx) begin
        model_q[k].complete = 1;
        if (mp) model_q[k].mispredict = 1;
      end
    end
  endtask

  task automatic pushEntry(input int dest, input int prf, input int old_prf, input bit br);
    model_entry_t e;
    e.idx = model_tail; e.dest = dest; e.prf = prf; e.old_prf = old_prf;
    e.complete = 0; e.is_branch = br; e.mispredict = 0;
    model_q.push_back(e);
    model_tail = (model_tail + 1) % ROB_SIZE;
  endtask

  task automatic updateModel();
    bit stalled;
    stalled = model_q.size() > ROB_SIZE - 2;
    if (st_reset || exp_recover) begin
      model_q.delete();
      model_tail = 0;
      return;
    end
    markComplete(st_c1, st_ci1, st_mp1);
    markComplete(st_c2, st_ci2, st_mp2);
    if (exp_commit_1) void'(model_q.pop_front());
    if (exp_commit_2) void'(model_q.pop_front());
    if (st_d1 && !stalled) begin
      pushEntry(st_dest1, st_prf1, st_old1, st_br1);
      if (st_d2) pushEntry(st_dest2, st_prf2, st_old2, st_br2);
    end
  endtask

  task automatic driveInputs();
    reset                  = st_reset;
    dispatch_en_1          = st_d1;
    dispatch_en_2          = st_d2;
    dispatch_dest_reg_1    = ARF_IDX'(st_dest1);
    dispatch_dest_reg_2    = ARF_IDX'(st_dest2);
    dispatch_PRF_reg_1     = PRF_IDX'(st_prf1);
    dispatch_PRF_reg_2     = PRF_IDX'(st_prf2);
    dispatch_old_PRF_reg_1 = PRF_IDX'(st_old1);
    dispatch_old_PRF_reg_2 = PRF_IDX'(st_old2);
    complete_en_1          = st_c1;
    complete_en_2          = st_c2;
    complete_rob_idx_1     = ROB_IDX'(st_ci1);
    complete_rob_idx_2     = ROB_IDX'(st_ci2);
`ifdef ROB_ENABLE_BRANCH_RECOVERY_EN
    dispatch_is_branch_1   = st_br1;
    dispatch_is_branch_2   = st_br2;
    complete_mispredict_1  = st_mp1;
    complete_mispredict_2  = st_mp2;
`endif
  endtask

  // One clock: drive at negedge, compare against the model, advance the model at posedge.
  task automatic applyStimulus();
    @(negedge clock);
    // Dispatch into a stalled buffer is illegal, so the bench never issues it.
    if (model_q.size() > ROB_SIZE - 2) begin st_d1 = 0; st_d2 = 0; end
    driveInputs();
    #1;
    computeExpected();
    checkOutput("ROB_empty", ROB_empty, model_q.size() == 0);
    checkOutput("rob_stall", rob_stall, model_q.size() > ROB_SIZE - 2);
    checkOutput("rob_idx_1", rob_idx_1, model_tail);
    checkOutput("rob_idx_2", rob_idx_2, (model_tail + 1) % ROB_SIZE);
    checkOutput("commit_en_1", commit_en_1, exp_commit_1);
    checkOutput("commit_en_2", commit_en_2, exp_commit_2);
    if (exp_commit_1) begin
      checkOutput("ROB_dest_reg_1", ROB_dest_reg_1, model_q[0].dest);
      checkOutput("ROB_PRF_reg_1", ROB_PRF_reg_1, model_q[0].prf);
      checkOutput("ROB_old_PRF_reg_1", ROB_old_PRF_reg_1, model_q[0].old_prf);
    end
    if (exp_commit_2) begin
      checkOutput("ROB_dest_reg_2", ROB_dest_reg_2, model_q[1].dest);
      checkOutput("ROB_PRF_reg_2", ROB_PRF_reg_2, model_q[1].prf);
      checkOutput("ROB_old_PRF_reg_2", ROB_old_PRF_reg_2, model_q[1].old_prf);
    end
`ifdef ROB_ENABLE_BRANCH_RECOVERY_EN
    checkOutput("branch_recover", branch_recover, exp_recover);
`endif
    @(posedge clock);
    updateModel();
    #2;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clearStimulus();
    st_reset = 1;
    driveInputs();
    repeat (2) @(posedge clock);
    #2;
    checkOutput("reset_empty", ROB_empty, 1);
    checkOutput("reset_idx_1", rob_idx_1, 0);
    checkOutput("reset_idx_2", rob_idx_2, 1);
    checkOutput("reset_stall", rob_stall, 0);
    checkOutput("reset_commit_1", commit_en_1, 0);

    // Two dispatches, out-of-order completion, paired commit.
    clearStimulus();
    st_d1 = 1; st_d2 = 1;
    st_dest1 = 3; st_prf1 = 40; st_old1 = 7;
    st_dest2 = 5; st_prf2 = 41; st_old2 = 9;
    applyStimulus();
    checkOutput("tp_idx_1", rob_idx_1, 2);
    checkOutput("tp_idx_2", rob_idx_2, 3);
    checkOutput("tp_not_empty", ROB_empty, 0);
    clearStimulus(); st_c1 = 1; st_ci1 = 1;
    applyStimulus();
    checkOutput("tp_no_commit_young", commit_en_1, 0);
    clearStimulus(); st_c2 = 1; st_ci2 = 0;
    applyStimulus();
    checkOutput("tp_commit_1", commit_en_1, 1);
    checkOutput("tp_commit_2", commit_en_2, 1);
    checkOutput("tp_prf_1", ROB_PRF_reg_1, 40);
    checkOutput("tp_prf_2", ROB_PRF_reg_2, 41);
    checkOutput("tp_dest_2", ROB_dest_reg_2, 5);
    checkOutput("tp_old_1", ROB_old_PRF_reg_1, 7);
    clearStimulus();
    applyStimulus();
    checkOutput("tp_drained", ROB_empty, 1);

    // Fill to the stall threshold; a same-cycle commit must not lift the stall.
    for (int i = 0; i < 15; i++) begin
      clearStimulus(); st_d1 = 1; st_d2 = 1;
      applyStimulus();
    end
    checkOutput("fill30_stall", rob_stall, 0);
    clearStimulus(); st_d1 = 1;
    applyStimulus();
    checkOutput("fill31_stall", rob_stall, 1);
    clearStimulus(); st_c1 = 1; st_ci1 = model_q[0].idx;
    applyStimulus();
    checkOutput("stall_commit_cycle_commit", commit_en_1, 1);
    checkOutput("stall_commit_cycle_stall", rob_stall, 1);
    clearStimulus();
    applyStimulus();
    checkOutput("stall_released", rob_stall, 0);
    for (int i = 0; i < 40; i++) begin
      clearStimulus(); completeOldest();
      applyStimulus();
    end
    checkOutput("full_drain_empty", ROB_empty, 1);

    // Reset with live entries and a simultaneous dispatch.
    for (int i = 0; i < 5; i++) begin
      clearStimulus(); st_d1 = 1; st_d2 = 1;
      applyStimulus();
    end
    clearStimulus(); st_reset = 1; st_d1 = 1; st_d2 = 1;
    st_c1 = 1; st_ci1 = model_q[0].idx;
    applyStimulus();
    checkOutput("midreset_empty", ROB_empty, 1);
    checkOutput("midreset_idx_1", rob_idx_1, 0);
    checkOutput("midreset_idx_2", rob_idx_2, 1);
    checkOutput("midreset_commit", commit_en_1, 0);
    checkOutput("midreset_stall", rob_stall, 0);

    // Walk head to the last slot, then commit a pair that wraps.
    for (int i = 0; i < 80 && !(model_tail == ROB_SIZE - 1 && model_q.size() == 0); i++) begin
      clearStimulus();
      st_d1 = model_tail != ROB_SIZE - 1;
      completeOldest();
      applyStimulus();
    end
    checkOutput("wrap_setup_idx", rob_idx_1, ROB_SIZE - 1);
    clearStimulus(); st_d1 = 1; st_d2 = 1;
    applyStimulus();
    checkOutput("wrap_tail", rob_idx_1, 1);
    clearStimulus(); st_c1 = 1; st_ci1 = ROB_SIZE - 1; st_c2 = 1; st_ci2 = 0;
    applyStimulus();
    checkOutput("wrap_commit_1", commit_en_1, 1);
    checkOutput("wrap_commit_2", commit_en_2, 1);
    clearStimulus();
    applyStimulus();
    checkOutput("wrap_empty", ROB_empty, 1);
    checkOutput("wrap_head_idx", rob_idx_1, 1);

`ifdef ROB_ENABLE_BRANCH_RECOVERY_EN
    // Mispredicted branch at head: commits alone and flushes; a same-cycle dispatch is dropped.
    clearStimulus(); st_reset = 1;
    applyStimulus();
    clearStimulus(); st_d1 = 1; st_d2 = 1; st_br1 = 1;
    applyStimulus();
    clearStimulus(); st_c1 = 1; st_ci1 = 0; st_mp1 = 1; st_c2 = 1; st_ci2 = 1;
    applyStimulus();
    checkOutput("br_commit_1", commit_en_1, 1);
    checkOutput("br_commit_2", commit_en_2, 0);
    checkOutput("br_recover", branch_recover, 1);
    clearStimulus(); st_d1 = 1; st_d2 = 1;
    applyStimulus();
    checkOutput("br_flush_empty", ROB_empty, 1);
    checkOutput("br_flush_idx", rob_idx_1, 0);
`endif

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      clearStimulus();
      st_reset = $urandom_range(0, 199) == 0;
      st_d1    = $urandom_range(0, 3) != 0;
      st_d2    = $urandom_range(0, 1) != 0;
      if (model_q.size() > 0 && $urandom_range(0, 3) != 0) begin
        st_c1 = 1; st_ci1 = model_q[$urandom_range(0, model_q.size() - 1)].idx;
      end else begin
        st_c1 = $urandom_range(0, 1) != 0; st_ci1 = $urandom_range(0, ROB_SIZE - 1);
      end
      if (model_q.size() > 0 && $urandom_range(0, 2) != 0) begin
        st_c2 = 1; st_ci2 = model_q[$urandom_range(0, model_q.size() - 1)].idx;
      end else begin
        st_c2 = $urandom_range(0, 1) != 0; st_ci2 = st_ci1;
      end
`ifdef ROB_ENABLE_BRANCH_RECOVERY_EN
      st_br1 = $urandom_range(0, 7) == 0;
      st_br2 = $urandom_range(0, 7) == 0;
      st_mp1 = $urandom_range(0, 3) == 0;
      st_mp2 = $urandom_range(0, 3) == 0;
`endif
      applyStimulus();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
